// File: rtl/fsmc_sram_mailbox.sv
// fsmc_sram_mailbox: SRAM-port register file with TX/RX word FIFOs bridging an MCU to AXIS streams
module fsmc_sram_mailbox #(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] ID_VALUE   = 16'hA55A,
  parameter int          SIM_DELAY  = 0
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        sram_en,
  input  logic [1:0]  sram_wen,
  input  logic [15:0] sram_addr,
  input  logic [15:0] sram_din,
  output logic [15:0] sram_dout,
  output logic [15:0] m_axis_data,
  output logic        m_axis_valid,
  input  logic        m_axis_ready,
  input  logic [15:0] s_axis_data,
  input  logic        s_axis_valid,
  output logic        s_axis_ready,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  logic [15:0] tx_mem [FIFO_DEPTH];
  logic [15:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d, rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [3:0] en_q, en_d, sts_q, sts_d, ev, w1c;
  logic [15:0] dout_q, dout_d, rdata;
  logic irq_q, irq_d;
  logic hit, rd, wr, tx_wr, tx_push, tx_pop, tx_flush, rx_rd, rx_push, rx_pop, rx_flush;
  logic [2:0] a;
  // output delays are not modelled in synthesizable logic
  logic unused_sim_delay;
  assign unused_sim_delay = SIM_DELAY != 0;
  assign sram_dout    = dout_q;
  assign irq          = irq_q;
  assign m_axis_data  = tx_mem[tx_rp_q];
  assign m_axis_valid = tx_cnt_q != '0;
  assign s_axis_ready = ~areset & (rx_cnt_q != FULL);
  always_comb begin
    a        = sram_addr[2:0];
    hit      = sram_en & ~|sram_addr[15:3];
    rd       = sram_en & ~|sram_wen;
    wr       = hit & |sram_wen;
    tx_wr    = wr & (a == 3'd2);
    tx_pop   = m_axis_valid & m_axis_ready;
    tx_push  = tx_wr & (&sram_wen) & ((tx_cnt_q != FULL) | tx_pop);
    tx_flush = wr & (a == 3'd1) & sram_wen[0] & sram_din[0];
    rx_flush = wr & (a == 3'd1) & sram_wen[0] & sram_din[1];
    rx_rd    = rd & hit & (a == 3'd3);
    rx_pop   = rx_rd & (rx_cnt_q != '0);
    rx_push  = s_axis_valid & s_axis_ready;
    ev[0]    = rx_push & (rx_cnt_q == '0) & ~rx_flush;
    ev[1]    = tx_pop & ~tx_push & (tx_cnt_q == CW'(1)) & ~tx_flush;
    ev[2]    = tx_wr & ~tx_push;
    ev[3]    = rx_rd & (rx_cnt_q == '0);
    // a W1C and a new event on the same bit leave it set
    w1c      = (wr & (a == 3'd6) & sram_wen[0]) ? sram_din[3:0] : '0;
    sts_d    = (sts_q & ~w1c) | ev;
    en_d     = (wr & (a == 3'd5) & sram_wen[0]) ? sram_din[3:0] : en_q;
    irq_d    = |(sts_q & en_q);
    rdata    = (a == 3'd0) ? ID_VALUE :
               (a == 3'd3) ? (rx_pop ? rx_mem[rx_rp_q] : 16'h0) :
               (a == 3'd4) ? {8'(rx_cnt_q), 8'(tx_cnt_q)} :
               (a == 3'd5) ? {12'h0, en_q} :
               (a == 3'd6) ? {12'h0, sts_q} : 16'h0;
    dout_d   = rd ? (hit ? rdata : 16'h0) : dout_q;
    tx_cnt_d = tx_flush ? '0 : tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    tx_wp_d  = tx_flush ? '0 : tx_wp_q + AW'(tx_push);
    tx_rp_d  = tx_flush ? '0 : tx_rp_q + AW'(tx_pop);
    rx_cnt_d = rx_flush ? '0 : rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    rx_wp_d  = rx_flush ? '0 : rx_wp_q + AW'(rx_push);
    rx_rp_d  = rx_flush ? '0 : rx_rp_q + AW'(rx_pop);
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
      en_q     <= '0;
      sts_q    <= '0;
      dout_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      rx_cnt_q <= rx_cnt_d;
      en_q     <= en_d;
      sts_q    <= sts_d;
      dout_q   <= dout_d;
      irq_q    <= irq_d;
    end
  end
  always_ff @(posedge aclk) begin
    if (tx_push) tx_mem[tx_wp_q] <= sram_din;
    if (rx_push) rx_mem[rx_wp_q] <= s_axis_data;
  end
endmodule

// File: tb/tb_fsmc_sram_mailbox.sv
// tb_fsmc_sram_mailbox: scoreboard bench with a queue-based reference model of the mailbox
module tb_fsmc_sram_mailbox;
  localparam int D = 16;
  logic aclk = 0, areset = 1, sram_en = 0;
  logic [1:0] sram_wen = 0;
  logic [15:0] sram_addr = 0, sram_din = 0, sram_dout, m_axis_data, s_axis_data = 0;
  logic m_axis_valid, m_axis_ready = 0, s_axis_valid = 0, s_axis_ready, irq;
  always #5 aclk = ~aclk;
  fsmc_sram_mailbox #(.FIFO_DEPTH(D)) dut (
    .aclk(aclk), .areset(areset), .sram_en(sram_en), .sram_wen(sram_wen),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout),
    .m_axis_data(m_axis_data), .m_axis_valid(m_axis_valid), .m_axis_ready(m_axis_ready),
    .s_axis_data(s_axis_data), .s_axis_valid(s_axis_valid), .s_axis_ready(s_axis_ready),
    .irq(irq)
  );
  int n_cmp = 0, n_bad = 0;
  logic [15:0] tx_q[$], rx_q[$], rd_exp[$], st_exp[$];
  logic [3:0] m_sts = 0, m_en = 0;
  logic m_irq = 0;
  logic [15:0] dout_exp = 0;
  bit live = 0, started = 0, rd_pend = 0;
  bit mr = 0, sv = 0;
  logic [15:0] sd = 0;

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, advance the model by the same cycle
  task automatic step(bit rst, bit e, logic [1:0] w, logic [15:0] ad, logic [15:0] dn);
    logic [15:0] tq[$], rq[$];
    logic [3:0] ev, sts_n, en_n;
    logic [2:0] a;
    bit hit, wr, rdq, tpop, tpush, rpush, tfl, rfl, irq_n;
    int tn, rn;
    areset = rst; sram_en = e; sram_wen = w; sram_addr = ad; sram_din = dn;
    m_axis_ready = mr; s_axis_valid = sv; s_axis_data = sd;
    tq = {}; rq = {}; sts_n = 0; en_n = 0;
    if (rst) begin
      started = 1;
      rd_exp.push_back(16'h0);
    end else begin
      a = ad[2:0]; hit = e && ad[15:3] == 0; wr = hit && w != 0; rdq = e && w == 0;
      tq = tx_q; rq = rx_q; tn = tx_q.size(); rn = rx_q.size(); ev = 0;
      tfl = wr && a == 1 && w[0] && dn[0];
      rfl = wr && a == 1 && w[0] && dn[1];
      tpop = tn > 0 && mr;
      if (tpop) st_exp.push_back(tq.pop_front());
      tpush = 0;
      if (wr && a == 2) begin
        if (w != 2'b11 || (tn == D && !tpop)) ev[2] = 1;
        else begin tq.push_back(dn); tpush = 1; end
      end
      if (tn == 1 && tpop && !tpush && !tfl) ev[1] = 1;
      rpush = sv && rn < D;
      if (rdq) begin
        if (!hit) rd_exp.push_back(16'h0);
        else case (a)
          3'd0: rd_exp.push_back(16'hA55A);
          3'd3: if (rn > 0) rd_exp.push_back(rq.pop_front());
                else begin rd_exp.push_back(16'h0); ev[3] = 1; end
          3'd4: rd_exp.push_back({8'(rn), 8'(tn)});
          3'd5: rd_exp.push_back({12'h0, m_en});
          3'd6: rd_exp.push_back({12'h0, m_sts});
          default: rd_exp.push_back(16'h0);
        endcase
      end
      if (rpush) begin
        if (rn == 0 && !rfl) ev[0] = 1;
        rq.push_back(sd);
      end
      if (tfl) tq = {};
      if (rfl) rq = {};
      sts_n = ((wr && a == 6 && w[0]) ? (m_sts & ~dn[3:0]) : m_sts) | ev;
      en_n = (wr && a == 5 && w[0]) ? dn[3:0] : m_en;
    end
    irq_n = rst ? 1'b0 : |(m_sts & m_en);
    @(posedge aclk);
    tx_q = tq; rx_q = rq; m_sts = sts_n; m_en = en_n; m_irq = irq_n;
    if (rst) live = 1;
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) step(0, 0, 2'b00, 16'h0, 16'h0);
  endtask
  task automatic wr(logic [15:0] ad, logic [15:0] dn, logic [1:0] w = 2'b11);
    step(0, 1, w, ad, dn);
  endtask
  task automatic rd(logic [15:0] ad);
    step(0, 1, 2'b00, ad, 16'h0);
  endtask

  always @(negedge aclk) begin
    if (live) begin
      if (rd_pend) begin
        if (rd_exp.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rd_scoreboard: read data %h with no expected entry", sram_dout);
        end else dout_exp = rd_exp.pop_front();
      end
      chk("sram_dout", sram_dout, dout_exp);
      chk("m_axis_valid", {15'h0, m_axis_valid}, {15'h0, tx_q.size() > 0});
      chk("s_axis_ready", {15'h0, s_axis_ready}, {15'h0, !areset && rx_q.size() < D});
      chk("irq", {15'h0, irq}, {15'h0, m_irq});
      if (!areset && m_axis_valid && m_axis_ready) begin
        if (st_exp.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL m_axis_scoreboard: beat %h with no expected entry", m_axis_data);
        end else chk("m_axis_data", m_axis_data, st_exp.pop_front());
      end
    end
    rd_pend = started && ((sram_en && sram_wen == 2'b00) || areset);
  end

  initial begin
    logic [15:0] ad, dn;
    logic [1:0] w;
    int r;
    repeat (2) @(posedge aclk);
    #1;
    step(1, 0, 2'b00, 16'h0, 16'h0);
    rd(0); rd(4); rd(6); idle(2);
    mr = 0;
    for (int i = 1; i <= D + 1; i++) wr(2, 16'h1110 + 16'(i));
    rd(4); rd(6);
    mr = 1; idle(D + 2);
    rd(6); rd(4); wr(6, 16'h000F);
    wr(5, 16'h0001);
    sv = 1; sd = 16'hBEEF; idle(1);
    sd = 16'hCAFE; idle(1);
    sv = 0; idle(3);
    rd(3); rd(3); rd(3); rd(6); wr(6, 16'h000F); idle(3);
    sv = 1;
    for (int i = 0; i < D; i++) begin sd = 16'h2000 + 16'(i); idle(1); end
    sd = 16'h3000; rd(3);
    idle(1);
    sv = 0; rd(4);
    repeat (D + 1) rd(3);
    wr(6, 16'h000F);
    mr = 0;
    wr(2, 16'h5555, 2'b01); rd(6);
    wr(2, 16'h0A01); wr(2, 16'h0A02); wr(2, 16'h0A03);
    sv = 1; sd = 16'h0B01; idle(1); sd = 16'h0B02; idle(1); sv = 0;
    rd(4); wr(1, 16'h0003); rd(4); rd(1); wr(6, 16'h000F);
    wr(2, 16'h0C01); wr(2, 16'h0C02); wr(2, 16'h0C03); wr(5, 16'h000F);
    sv = 1; sd = 16'h0D01; idle(1); sd = 16'h0D02; idle(1);
    mr = 1; idle(1);
    step(1, 0, 2'b00, 16'h0, 16'h0);
    sv = 0; mr = 0;
    rd(4); rd(6); rd(5); idle(2);
    repeat (1500) begin
      mr = $urandom_range(0, 3) != 0;
      sv = $urandom_range(0, 1) == 1;
      sd = 16'($urandom);
      r = $urandom_range(0, 15);
      ad = r < 8 ? 16'(r) : (r < 12 ? 16'd2 : 16'd3);
      if ($urandom_range(0, 19) == 0) ad[15:3] = 13'($urandom_range(1, 8191));
      w = 2'($urandom_range(0, 3));
      if (ad[2:0] == 3'd3 && $urandom_range(0, 1) == 1) w = 2'b00;
      if (ad[2:0] == 3'd2 && $urandom_range(0, 3) != 0) w = 2'b11;
      dn = 16'($urandom);
      if (ad[2:0] == 3'd1 && $urandom_range(0, 3) != 0) dn[1:0] = 2'b00;
      if ($urandom_range(0, 399) == 0) step(1, 0, 2'b00, 16'h0, 16'h0);
      else step(0, $urandom_range(0, 3) != 0, w, ad, dn);
    end
    sv = 0; mr = 1;
    rd(4); rd(6); idle(D + 2); rd(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
